// File: rtl/pair_mac_pkg.sv
// Shared widths and FSM state type for the pair multiply-accumulate engine.
package pair_mac_pkg;

    localparam int SHORT_WIDTH    = 16;
    localparam int PRODUCT_WIDTH  = 32;
    localparam int PAIR_SUM_WIDTH = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pair_mult.sv
// One registered stage: two signed 16x16 products from a RAM word and their
// 33-bit sum, with a travelling valid bit.
module pair_mult
    import pair_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 64
)
(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            word,
    output logic                             out_valid,
    output logic signed [PAIR_SUM_WIDTH-1:0] pair_sum
);

    logic signed [PRODUCT_WIDTH-1:0]  prod [2];
    logic signed [PAIR_SUM_WIDTH-1:0] sum_next;

    // Product gi multiplies short 2*gi by short 2*gi+1.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_prod
            assign prod[gi] = $signed(word[gi*2*SHORT_WIDTH +: SHORT_WIDTH])
                            * $signed(word[gi*2*SHORT_WIDTH+SHORT_WIDTH +: SHORT_WIDTH]);
        end
    endgenerate

    assign sum_next = PAIR_SUM_WIDTH'(prod[0]) + PAIR_SUM_WIDTH'(prod[1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            pair_sum  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                pair_sum <= sum_next;
            end
        end
    end

endmodule

// File: rtl/pair_mac_engine.sv
// Streams a block of RAM words, multiplies short pairs within each word and
// accumulates a signed sum with a sticky overflow flag.
module pair_mac_engine
    import pair_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_WIDTH  = 48
)
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH:0]         length,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    input  logic [DATA_WIDTH-1:0]       ram_q,
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        overflow
);

    state_t                           state_reg, state_next;
    logic [ADDR_WIDTH-1:0]            addr_reg;
    logic [ADDR_WIDTH:0]              remaining_reg;
    logic                             q_valid_reg;
    logic                             done_reg;
    logic                             overflow_reg;
    logic signed [ACC_WIDTH-1:0]      result_reg;
    logic signed [ACC_WIDTH-1:0]      acc_add;
    logic signed [ACC_WIDTH-1:0]      acc_sum;
    logic                             acc_ovf;
    logic                             accept;
    logic                             mult_valid;
    logic signed [PAIR_SUM_WIDTH-1:0] pair_sum;

    assign accept = (state_reg == IDLE) && start;

    // A zero-length job goes straight to DRAIN, which then finishes at once
    // because no read is in flight.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (length != '0) ? FETCH : DRAIN;
            FETCH:   if (remaining_reg == '0) state_next = DRAIN;
            DRAIN:   if (!q_valid_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else if (accept && (length != '0)) begin
            addr_reg      <= base_addr;
            remaining_reg <= length - (ADDR_WIDTH+1)'(1);
        end else if ((state_reg == FETCH) && (remaining_reg != '0)) begin
            addr_reg      <= addr_reg + ADDR_WIDTH'(1);
            remaining_reg <= remaining_reg - (ADDR_WIDTH+1)'(1);
        end
    end

    // Every FETCH cycle presents one address; its data arrives a cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            q_valid_reg <= (state_reg == FETCH);
            done_reg    <= (state_reg == DRAIN) && !q_valid_reg;
        end
    end

    pair_mult #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pair_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (q_valid_reg),
        .word      (ram_q),
        .out_valid (mult_valid),
        .pair_sum  (pair_sum)
    );

    assign acc_add = ACC_WIDTH'(pair_sum);
    assign acc_sum = result_reg + acc_add;
    assign acc_ovf = (result_reg[ACC_WIDTH-1] == acc_add[ACC_WIDTH-1])
                  && (acc_sum[ACC_WIDTH-1] != result_reg[ACC_WIDTH-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (mult_valid) begin
            result_reg <= acc_sum;
            if (acc_ovf) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign ram_addr = addr_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign result   = result_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pair_mac_engine.sv
// Directed bench: table of jobs with hand-computed sums, plus reset, held-start
// and narrow-accumulator overflow sequences.
module tb_pair_mac_engine;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start, start33;
    logic [7:0]         base_addr, base33;
    logic [8:0]         length, length33;
    logic [7:0]         ram_addr, ram_addr33;
    logic [63:0]        ram_q, ram_q33;
    logic               busy, done, overflow;
    logic               busy33, done33, overflow33;
    logic signed [47:0] result;
    logic signed [32:0] result33;
    logic [63:0]        mem [256];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_hold = 8'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_q   <= mem[ram_addr];
        ram_q33 <= mem[ram_addr33];
    end

    pair_mac_engine u_dut (
        .clk (clk), .reset_n (reset_n), .start (start), .base_addr (base_addr),
        .length (length), .ram_addr (ram_addr), .ram_q (ram_q), .busy (busy),
        .done (done), .result (result), .overflow (overflow)
    );

    pair_mac_engine #(.ACC_WIDTH(33)) u_dut33 (
        .clk (clk), .reset_n (reset_n), .start (start33), .base_addr (base33),
        .length (length33), .ram_addr (ram_addr33), .ram_q (ram_q33), .busy (busy33),
        .done (done33), .result (result33), .overflow (overflow33)
    );

    typedef struct {
        logic [7:0]         base;
        logic [8:0]         len;
        logic [63:0]        word;
        logic signed [47:0] exp_res;
        logic               exp_ovf;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [63:0] mk(input logic [15:0] s3, input logic [15:0] s2,
                                       input logic [15:0] s1, input logic [15:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] b, input int n, input logic [63:0] w);
        for (int i = 0; i < n; i++) mem[8'(b + 8'(i))] = w;
    endtask

    task automatic run_job(input int idx, input logic [7:0] b, input logic [8:0] l,
                           input logic signed [47:0] er, input logic eo);
        int n;
        int done_at;
        int exp_done;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_e0", busy, 1);
        check("result_cleared", result, 0);
        check("addr_e0", ram_addr, (l == 0) ? exp_hold : b);
        done_at = -1;
        n = 0;
        while (done_at < 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n < int'(l)) check("addr_seq", ram_addr, 8'(b + 8'(n)));
            if (done) done_at = n;
        end
        exp_done = (l == 0) ? 1 : int'(l) + 2;
        check("done_edge", done_at, exp_done);
        check("busy_at_done", busy, 0);
        check("result", result, er);
        check("overflow", overflow, eo);
        if (l != 0) exp_hold = 8'(b + 8'(l) - 8'd1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("result_stable", result, er);
        check("addr_hold", ram_addr, exp_hold);
        $display("job %0d base=%0d len=%0d result=%0d overflow=%0d done_edge=%0d",
                 idx, b, l, result, overflow, done_at);
    endtask

    initial begin
        int n;
        int pulses;
        int done_at;

        vecs[0] = '{8'd0,   9'd1,   mk(16'd4, 16'd3, 16'd2, 16'd1), 48'sd14, 1'b0};
        vecs[1] = '{8'd254, 9'd4,   mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 48'sd8, 1'b0};
        vecs[2] = '{8'd10,  9'd0,   64'd0, 48'sd0, 1'b0};
        vecs[3] = '{8'd20,  9'd3,   mk(16'hFFFE, 16'd5, 16'd7, 16'hFFFD), -48'sd93, 1'b0};
        vecs[4] = '{8'd100, 9'd5,   mk(16'h8000, 16'h8000, 16'h8000, 16'h8000), 48'sd10737418240, 1'b0};
        vecs[5] = '{8'd200, 9'd2,   mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000), -48'sd4294836224, 1'b0};
        vecs[6] = '{8'd0,   9'd256, mk(16'd1, 16'd1, 16'd1, 16'd1), 48'sd512, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        reset_n = 1'b0;
        start = 1'b0; base_addr = 8'd0; length = 9'd0;
        start33 = 1'b0; base33 = 8'd0; length33 = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_busy33", busy33, 0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset released");

        for (int i = 0; i < 7; i++) begin
            fill(vecs[i].base, int'(vecs[i].len), vecs[i].word);
            run_job(i, vecs[i].base, vecs[i].len, vecs[i].exp_res, vecs[i].exp_ovf);
        end

        // Reset in the middle of a length-8 job.
        fill(8'd0, 8, mk(16'd0, 16'd0, 16'd1, 16'd1));
        @(negedge clk);
        start = 1'b1; base_addr = 8'd0; length = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_addr", ram_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        exp_hold = 8'd0;
        $display("mid-job reset applied, pulses after release=%0d", pulses);
        run_job(7, 8'd0, 9'd1, 48'sd1, 1'b0);

        // Start held high; base/length change mid-job must not matter.
        fill(8'd30, 11, mk(16'd0, 16'd0, 16'd1, 16'd2));
        @(negedge clk);
        start = 1'b1; base_addr = 8'd30; length = 9'd3;
        @(posedge clk); #1;
        base_addr = 8'd33; length = 9'd5;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (k < 5) check("held_busy", busy, 1);
        end
        check("held_pulses", pulses, 1);
        check("held_done_e5", done, 1);
        check("held_result", result, 6);
        $display("held-start job1 result=%0d pulses=%0d", result, pulses);
        @(posedge clk); #1;
        start = 1'b0;
        check("held_restart_busy", busy, 1);
        check("held_restart_addr", ram_addr, 33);
        check("held_restart_done", done, 0);
        done_at = -1;
        n = 0;
        while (done_at < 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (done) done_at = n;
        end
        check("held_job2_done_edge", done_at, 7);
        check("held_job2_result", result, 10);
        $display("held-start job2 result=%0d done_edge=%0d", result, done_at);

        // 33-bit accumulator: 4 * 2^31 wraps to 0 with overflow.
        fill(8'd0, 4, mk(16'h8000, 16'h8000, 16'h8000, 16'h8000));
        @(negedge clk);
        start33 = 1'b1; base33 = 8'd0; length33 = 9'd4;
        @(posedge clk); #1;
        start33 = 1'b0;
        check("acc33_busy_e0", busy33, 1);
        done_at = -1;
        n = 0;
        while (done_at < 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (n == 4) begin
                check("acc33_mid_result", result33, -64'sd4294967296);
                check("acc33_mid_overflow", overflow33, 1);
            end
            if (done33) done_at = n;
        end
        check("acc33_done_edge", done_at, 6);
        check("acc33_result", result33, 0);
        check("acc33_overflow", overflow33, 1);
        $display("acc33 job result=%0d overflow=%0d done_edge=%0d", result33, overflow33, done_at);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pair_mac_engine.md
PAIR_MAC_ENGINE -- requirements
Module: pair_mac_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, RAM word width holding four signed 16-bit shorts.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, accumulator/result width.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports clk and reset_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  job request, sampled only in IDLE.
REQ-008 base_addr  input  ADDR_WIDTH  first RAM word of job.
REQ-009 length  input  ADDR_WIDTH+1  number of words (0..2^ADDR_WIDTH).
REQ-010 ram_addr  output  ADDR_WIDTH  read address to upstream single-port RAM.
REQ-011 ram_q  input  DATA_WIDTH  RAM read data, valid one clock after ram_addr is sampled.
REQ-012 busy  output  1  high while a job is in progress.
REQ-013 done  output  1  one-cycle pulse at job completion.
REQ-014 result  output  ACC_WIDTH  signed sum of products of the last job.
REQ-015 overflow  output  1  sticky signed-overflow flag for the last job.

Function
REQ-016 Each word SHALL contribute q[15:0]*q[31:16] + q[47:32]*q[63:48], all operands signed 16-bit, products 32-bit signed, pair sum 33-bit, sign-extended to ACC_WIDTH.
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN: IDLE->FETCH on start with length>0; FETCH->DRAIN after the last address is issued; DRAIN->IDLE when the final accumulate completes.
REQ-018 Start accepted at edge E0 SHALL clear result and overflow, load ram_addr=base_addr, assert busy.
REQ-019 In FETCH, ram_addr SHALL increment by 1 per clock, wrapping modulo 2^ADDR_WIDTH; word k is presented from Ek to Ek+1.
REQ-020 Pipeline: products of word k registered at Ek+2, accumulated into result at Ek+3.
REQ-021 done SHALL pulse high for exactly one cycle starting at edge E(length+2); busy SHALL fall at the same edge.
REQ-022 start with length=0 SHALL issue no reads, leave result=0 and overflow=0, pulse done at E1, busy high only E0..E1.
REQ-023 start while busy SHALL be ignored; inputs base_addr/length SHALL be captured only at E0.
REQ-024 Accumulation SHALL wrap two's complement; overflow SHALL set on any signed overflow of an accumulate and hold until next accepted start.
REQ-025 result and overflow SHALL remain stable between done and the next accepted start.
REQ-026 ram_addr SHALL hold its last value while IDLE.

Reset
REQ-027 reset_n low SHALL force state=IDLE, ram_addr=0, busy=0, done=0, result=0, overflow=0, pipeline valids=0, asynchronously.
REQ-028 Reset asserted mid-job SHALL abandon the job with no done pulse; first start after release behaves as from power-up.

Structure
REQ-029 Package pair_mac_pkg SHALL hold SHORT_WIDTH=16, PRODUCT_WIDTH=32, PAIR_SUM_WIDTH=33, and the FSM state type.
REQ-030 Sub-module pair_mult SHALL compute and register the two products and their sum (one pipeline stage, with valid).
REQ-031 RAM port arbitration and RAM write path are outside this block.

Verification
REQ-032 RAM[0]={s3=4,s2=3,s1=2,s0=1}; start base=0 length=1 -> done at E3, result=14, overflow=0.
REQ-033 length=0 -> no ram_addr change, done at E1, result=0.
REQ-034 base=254 length=4, words all {-1,-1,-1,-1} -> ram_addr sequence 254,255,0,1; result=8; done at E6.
REQ-035 ACC_WIDTH=33, 4 words of {-32768,-32768,-32768,-32768} -> overflow=1, result equals wrapped two's-complement sum.
REQ-036 reset_n pulsed low at E2 of length=8 job -> all outputs 0, no done; new length=1 job after release completes normally.
REQ-037 start held high through a length=3 job -> exactly one done pulse; second job starts only on start seen in IDLE after done.
